// File: rtl/mux_seq_pkg.sv
// Shared constants and channel-selection helpers for the mux select sequencer.
package mux_seq_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;
   localparam logic [NCH-1:0] AN_OFF = 4'b1111;

   function automatic logic [NCH-1:0] onehot_n(input logic [SEL_W-1:0] sel);
      return ~(NCH'(1) << sel);
   endfunction

   // Scan backwards so the closest unmasked channel after sel wins; sel itself is the last resort.
   function automatic logic [SEL_W-1:0] next_unmasked(input logic [SEL_W-1:0] sel,
                                                      input logic [NCH-1:0]   mask);
      logic [SEL_W-1:0] res;
      logic [SEL_W-1:0] cand;
      res = sel;
      for (int k = NCH; k >= 1; k--) begin
         cand = sel + SEL_W'(k);
         if (!mask[cand]) res = cand;
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_seq_prescaler.sv
// Slot prescaler: counts 0..DIV-1 while en is high and holds while low.
// wrap is combinational and marks the last cycle of a slot.
module mux_seq_prescaler #(
   parameter int DIV   = 50000,
   localparam int CNT_W = $clog2(DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign wrap = en && (cnt_q == CNT_W'(DIV - 1));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Time-division select sequencer driving the 4-to-1 mux select and active-low channel enables.
// Optional anti-ghosting dead time at slot start when SEQ_BLANK_EN is defined.
module mux_sel_sequencer
   import mux_seq_pkg::*;
#(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [NCH-1:0] mask,
   output logic           s0,
   output logic           s1,
   output logic [NCH-1:0] an,
   output logic           tick,
   output logic           frame
);

   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);

   logic [CNT_W-1:0] cnt;
   logic             wrap;
   logic [CNT_W-1:0] cnt_nxt;
   logic             blank;

   logic [SEL_W-1:0] sel_q,   sel_d;
   logic [NCH-1:0]   an_q,    an_d;
   logic             tick_q,  tick_d;
   logic             frame_q, frame_d;

   mux_seq_prescaler #(.DIV(DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .cnt   (cnt),
      .wrap  (wrap)
   );

   // an is registered, so blanking is judged on the count the slot will show after this edge.
   assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
`ifdef SEQ_BLANK_EN
   assign blank = (cnt_nxt < BLANK_V);
`else
   assign blank = (cnt_nxt < BLANK_V) & 1'b0;
`endif

   always_comb begin
      sel_d   = wrap ? next_unmasked(sel_q, mask) : sel_q;
      tick_d  = wrap;
      frame_d = wrap && (sel_d <= sel_q);
      an_d    = (en && !mask[sel_d] && !blank) ? onehot_n(sel_d) : AN_OFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         an_q    <= AN_OFF;
         tick_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         an_q    <= an_d;
         tick_q  <= tick_d;
         frame_q <= frame_d;
      end
   end

   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign an    = an_q;
   assign tick  = tick_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer with DIV=4, BLANK_CYC=1 (blanking follows SEQ_BLANK_EN).
module tb_mux_sel_sequencer;

   localparam int DIV       = 4;
   localparam int BLANK_CYC = 1;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] mask;
   logic       s0, s1, tick, frame;
   logic [3:0] an;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] an;
      logic       tick;
      logic       frame;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   m_cnt = 0;
   int   m_sel = 0;

   mux_sel_sequencer #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mask  (mask),
      .s0    (s0),
      .s1    (s1),
      .an    (an),
      .tick  (tick),
      .frame (frame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sel"},   {30'd0, s1, s0}, 32'd0);
      check({tag, "_an"},    {28'd0, an}, 32'hF);
      check({tag, "_tick"},  {31'd0, tick}, 32'd0);
      check({tag, "_frame"}, {31'd0, frame}, 32'd0);
   endtask

   // Reference behaviour for one clock edge given the inputs currently driven.
   task automatic model_push();
      int   new_sel;
      int   new_cnt;
      int   c;
      bit   found;
      bit   wrap;
      bit   blank;
      exp_t e;
      wrap    = en && (m_cnt == DIV - 1);
      new_sel = m_sel;
      found   = 1'b0;
      if (wrap) begin
         for (int k = 1; k <= 4; k++) begin
            c = (m_sel + k) % 4;
            if (!found && !mask[c]) begin
               new_sel = c;
               found   = 1'b1;
            end
         end
      end
      new_cnt = !en ? m_cnt : (wrap ? 0 : m_cnt + 1);
`ifdef SEQ_BLANK_EN
      blank = (new_cnt < BLANK_CYC);
`else
      blank = 1'b0;
`endif
      e.sel   = 2'(new_sel);
      e.tick  = wrap;
      e.frame = wrap && (new_sel <= m_sel);
      e.an    = (en && !mask[new_sel] && !blank) ? ~(4'b0001 << new_sel) : 4'hF;
      m_cnt   = new_cnt;
      m_sel   = new_sel;
      sb.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("sel",   {30'd0, s1, s0}, {30'd0, e.sel});
         check("an",    {28'd0, an},     {28'd0, e.an});
         check("tick",  {31'd0, tick},   {31'd0, e.tick});
         check("frame", {31'd0, frame},  {31'd0, e.frame});
      end
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      int g;
      rst_n = 1'b1;
      en    = 1'b0;
      mask  = 4'b0000;
      #3 rst_n = 1'b0;
      #1 check_reset("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_cnt = 0;
      m_sel = 0;

      // full rotation
      en   = 1'b1;
      mask = 4'b0000;
      run(20);

      // channels 1 and 3 only
      mask = 4'b0101;
      run(16);

      // pause mid-slot at cnt=2
      mask = 4'b0000;
      g = 0;
      while (m_cnt != 2 && g < 16) begin
         cycle();
         g++;
      end
      if (g >= 16) check("sync_cnt_timeout", g, 0);
      en = 1'b0;
      cycle();
      check("en_off_an", {28'd0, an}, 32'hF);
      run(4);
      en = 1'b1;
      run(8);

      // everything masked
      mask = 4'b1111;
      run(12);

      // async reset mid-slot with sel=2
      mask = 4'b0000;
      g = 0;
      while (!(m_sel == 2 && m_cnt == 1) && g < 32) begin
         cycle();
         g++;
      end
      if (g >= 32) check("sync_sel_timeout", g, 0);
      #2 rst_n = 1'b0;
      #1 check_reset("rst_mid");
      m_cnt = 0;
      m_sel = 0;
      @(posedge clk);
      #1 check_reset("rst_hold");
      rst_n = 1'b1;
      run(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
